binary_to_bcd_converter: RTL

BINARY_TO_BCD_CONVERTER -- requirements
Module: binary_to_bcd_converter

---
 rtl/binary_to_bcd_converter_pkg.sv | 33 +++
 rtl/binary_to_bcd_converter_if.sv | 46 ++++
 rtl/binary_to_bcd_converter_bcd_digit_adjust.sv | 26 ++
 rtl/binary_to_bcd_converter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/binary_to_bcd_converter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_converter_pkg
// Description : Shared definitions for the binary-to-BCD converter. Holds the
//               BCD digit width, the converter FSM state encoding and a
//               constant function returning 10^N-1 for a given N.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_to_bcd_converter_pkg;

    // Bits per BCD digit (nybble).
    localparam int BCD_DIGIT_WIDTH = 4;

    // Converter FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Largest value representable in n BCD digits (10^n - 1). The result is
    // 64 bits wide, which is exact for n up to 19.
    function automatic logic [63:0] max_bcd_value(input int n);
        logic [63:0] power;
        power = 64'd1;
        for (int i = 0; i < n; i++) begin
            power = power * 64'd10;
        end
        return power - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_converter_if
// Description : Request/result bundle of the binary-to-BCD converter.
//   start    - request a conversion (master -> slave)
//   binary   - unsigned operand (master -> slave)
//   busy     - converter is in SHIFT or DONE (slave -> master)
//   valid    - one-cycle pulse when bcd/overflow update (slave -> master)
//   bcd      - packed BCD result, digit 0 in bits [3:0] (slave -> master)
//   overflow - last operand exceeded 10^NUMBER_OF_NYBBLES-1 (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface binary_to_bcd_converter_if
    import binary_to_bcd_converter_pkg::*;
#(
    parameter int BINARY_WIDTH      = 27,
    parameter int NUMBER_OF_NYBBLES = 8
);

    logic                                          start;
    logic [BINARY_WIDTH-1:0]                       binary;
    logic                                          busy;
    logic                                          valid;
    logic [NUMBER_OF_NYBBLES*BCD_DIGIT_WIDTH-1:0]  bcd;
    logic                                          overflow;

    modport master (
        output start,
        output binary,
        input  busy,
        input  valid,
        input  bcd,
        input  overflow
    );

    modport slave (
        input  start,
        input  binary,
        output busy,
        output valid,
        output bcd,
        output overflow
    );

endinterface
`default_nettype wire

// File: rtl/binary_to_bcd_converter_bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Double-dabble digit correction. Adds 3 to a BCD digit that is
//               5 or more, so the following left shift carries correctly
//               into the next decimal digit.
//   digit_in  - scratch digit before correction
//   digit_out - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import binary_to_bcd_converter_pkg::*;
(
    input  logic [BCD_DIGIT_WIDTH-1:0] digit_in,
    output logic [BCD_DIGIT_WIDTH-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_converter
// Description : Sequential double-dabble binary-to-BCD converter. One operand
//               bit is consumed per clock; the result appears BINARY_WIDTH+1
//               cycles after the accepted start.
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - slave side of binary_to_bcd_converter_if
//           (start/binary in; busy/valid/bcd/overflow out)
// Configuration macro:
//   BCD_OVERFLOW_SATURATE_EN - when defined, an overflowed conversion loads
//                              bcd with all nines; otherwise bcd carries the
//                              operand modulo 10^NUMBER_OF_NYBBLES.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_converter
    import binary_to_bcd_converter_pkg::*;
#(
    parameter int BINARY_WIDTH      = 27,
    parameter int NUMBER_OF_NYBBLES = 8
)(
    input  logic                        clock,
    input  logic                        reset,
    binary_to_bcd_converter_if.slave    bus
);

    localparam int BCD_WIDTH = NUMBER_OF_NYBBLES * BCD_DIGIT_WIDTH;
    localparam int CNT_WIDTH = $clog2(BINARY_WIDTH + 1);
    // Comparison width wide enough for both the operand and 10^N-1.
    localparam int CMP_WIDTH = (BINARY_WIDTH > 64) ? BINARY_WIDTH : 64;

    localparam logic [CMP_WIDTH-1:0] C_MAX_VALUE =
        CMP_WIDTH'(max_bcd_value(NUMBER_OF_NYBBLES));
    localparam logic [CNT_WIDTH-1:0] C_CNT_LOAD  = CNT_WIDTH'(BINARY_WIDTH);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);

    state_t                  r_state;
    logic [BINARY_WIDTH-1:0] r_shift;
    logic [BCD_WIDTH-1:0]    r_scratch;
    logic [CNT_WIDTH-1:0]    r_count;
    logic                    r_ovf_captured;
    logic [BCD_WIDTH-1:0]    r_bcd;
    logic                    r_overflow;
    logic                    r_valid;
    logic                    r_busy;

    logic [CMP_WIDTH-1:0]    w_operand_ext;
    logic                    w_operand_overflow;
    logic [BCD_WIDTH-1:0]    w_adjusted;
    logic [BCD_WIDTH-1:0]    w_scratch_next;
    logic [BCD_WIDTH-1:0]    w_result;

    // Overflow is decided on the raw operand at capture time.
    assign w_operand_ext      = CMP_WIDTH'(bus.binary);
    assign w_operand_overflow = (w_operand_ext > C_MAX_VALUE);

    generate
        for (genvar g = 0; g < NUMBER_OF_NYBBLES; g++) begin : g_adjust
            bcd_digit_adjust u_bcd_digit_adjust (
                .digit_in  (r_scratch [g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH]),
                .digit_out (w_adjusted[g*BCD_DIGIT_WIDTH +: BCD_DIGIT_WIDTH])
            );
        end
    endgenerate

    // Shift the adjusted scratch left, pulling in the operand MSB. The bit
    // leaving the top nybble is a carry worth 10^N and is dropped, which
    // leaves the result equal to the operand modulo 10^N.
    assign w_scratch_next = {w_adjusted[BCD_WIDTH-2:0], r_shift[BINARY_WIDTH-1]};

`ifdef BCD_OVERFLOW_SATURATE_EN
    assign w_result = r_ovf_captured ? {NUMBER_OF_NYBBLES{4'h9}} : r_scratch;
`else
    assign w_result = r_scratch;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_shift        <= '0;
            r_scratch      <= '0;
            r_count        <= '0;
            r_ovf_captured <= 1'b0;
            r_bcd          <= '0;
            r_overflow     <= 1'b0;
            r_valid        <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shift        <= bus.binary;
                        r_scratch      <= '0;
                        r_count        <= C_CNT_LOAD;
                        r_ovf_captured <= w_operand_overflow;
                        r_busy         <= 1'b1;
                        r_state        <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shift   <= {r_shift[BINARY_WIDTH-2:0], 1'b0};
                    r_count   <= r_count - C_CNT_ONE;
                    // Last operand bit is shifted on this edge.
                    if (r_count == C_CNT_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd      <= w_result;
                    r_overflow <= r_ovf_captured;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.valid    = r_valid;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
